// File: rtl/stream_arb2.sv
// Two-requester stream arbiter with a single registered output stage.
// Round-robin between requesters using a priority bit; grant is combinational,
// so arbitration adds no bubble.
// Optional feature: define STREAM_ARB2_PKT_LOCK_EN to hold the grant on one
// requester from its first beat until its last beat (packet lock). With the
// macro undefined every accepted beat completes an arbitration and in*_last
// is only passed through.

module stream_arb2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src
);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e           state_q;
  logic             prio_q;

  logic             gnt_any;
  logic             gnt_sel;
  logic             out_free;
  logic             acc_any;
  logic [WIDTH-1:0] win_data;
  logic             win_last;

  // Grant selection from lock state, priority bit and the request valids.
  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = 1'b0;
    case (state_q)
      StLock0: begin
        gnt_any = 1'b1;
        gnt_sel = 1'b0;
      end
      StLock1: begin
        gnt_any = 1'b1;
        gnt_sel = 1'b1;
      end
      default: begin
        if (in0_valid && in1_valid) begin
          gnt_any = 1'b1;
          gnt_sel = prio_q;
        end else if (in1_valid) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b1;
        end else if (in0_valid) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b0;
        end
      end
    endcase
  end

  // Handshake: the output register can take a beat when empty or draining.
  // Readies are gated by rst_n so they are low throughout reset.
  always_comb begin
    out_free  = !out_valid || out_ready;
    in0_ready = rst_n && out_free && gnt_any && !gnt_sel;
    in1_ready = rst_n && out_free && gnt_any && gnt_sel;
    acc_any   = (in0_ready && in0_valid) || (in1_ready && in1_valid);
    win_data  = gnt_sel ? in1_data : in0_data;
    win_last  = gnt_sel ? in1_last : in0_last;
  end

  // Arbitration state, priority bit and the output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      prio_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else begin
      if (out_free) begin
        out_valid <= acc_any;
        if (acc_any) begin
          out_data <= win_data;
          out_last <= win_last;
          out_src  <= gnt_sel;
        end
      end
      if (acc_any) begin
`ifdef STREAM_ARB2_PKT_LOCK_EN
        // Only a last beat ends the arbitration; earlier beats lock the winner.
        if (win_last) begin
          state_q <= StIdle;
          prio_q  <= ~gnt_sel;
        end else begin
          state_q <= gnt_sel ? StLock1 : StLock0;
        end
`else
        prio_q <= ~gnt_sel;
`endif
      end
    end
  end

endmodule
